// File: rtl/pcie_flow_ctrl_rx_init.sv
// pcie_flow_ctrl_rx_init
// Receive side of DLL flow-control initialisation. Parses inbound DLLPs (one
// 4-byte header beat followed by one 2-byte CRC beat), checks the 16-bit DLLP
// CRC and captures the link partner's InitFC1/InitFC2 credits per type. The
// FC1/FC2 "values stored" flags go back to the init transmitter; the captured
// limits feed the TLP credit gate.
module pcie_flow_ctrl_rx_init #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3,
    parameter int VC_ID      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fc_init_en_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  fc1_values_stored_o,
    output logic                  fc2_values_stored_o,
    output logic [7:0]            ph_credits_o,
    output logic [7:0]            nph_credits_o,
    output logic [7:0]            cplh_credits_o,
    output logic [11:0]           pd_credits_o,
    output logic [11:0]           npd_credits_o,
    output logic [11:0]           cpld_credits_o,
    output logic                  crc_err_o
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("pcie_flow_ctrl_rx_init: only DATA_WIDTH=32 is supported");
    end

    localparam logic [2:0]            VC_SEL   = 3'(VC_ID);
    localparam logic [KEEP_WIDTH-1:0] KEEP_HDR = KEEP_WIDTH'(4'hF);
    localparam logic [KEEP_WIDTH-1:0] KEEP_CRC = KEEP_WIDTH'(4'h3);

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_CRC  = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FC1  = 2'd1,
        ST_FC2  = 2'd2,
        ST_DONE = 2'd3
    } init_state_t;

    // DLLP CRC: poly 16'h100B, bits fed from byte0 bit0 upward through byte3 bit7.
    function automatic logic [15:0] pcie_datalink_crc(input logic [15:0] crc_in,
                                                      input logic [31:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        return c;
    endfunction

    // Wire order of the CRC: bits mirrored inside each byte.
    function automatic logic [15:0] crc_wire_order(input logic [15:0] c);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[i]     = c[7-i];
            r[8 + i] = c[15-i];
        end
        return r;
    endfunction

    rx_state_t   rx_state_r;
    init_state_t init_state_r;
    logic [31:0] hdr_r;
    logic [15:0] crc_calc_r;
    logic        tready_r;
    logic        crc_err_r;
    logic        got_p_r, got_np_r, got_cpl_r;
    logic        fc1_r, fc2_r, fc2_pend_r;
    logic [7:0]  ph_r, nph_r, cplh_r;
    logic [11:0] pd_r, npd_r, cpld_r;

    logic        beat_acc_s;
    logic        crc_ok_s;
    logic        good_dllp_s;
    logic [3:0]  dllp_type_s;
    logic [2:0]  dllp_vc_s;
    logic [7:0]  hdr_fc_s;
    logic [11:0] data_fc_s;
    logic        is_init_s;
    logic        is_fc2_upd_s;
    logic [1:0]  fc_class_s;
    logic        unused_s;

    assign beat_acc_s    = s_axis_tvalid & tready_r;
    assign s_axis_tready = tready_r;

    assign dllp_type_s = hdr_r[7:4];
    assign dllp_vc_s   = hdr_r[2:0];
    assign hdr_fc_s    = {hdr_r[13:8], hdr_r[23:22]};
    assign data_fc_s   = {hdr_r[19:16], hdr_r[31:24]};
    assign fc_class_s  = hdr_r[5:4];

    // Scale fields, reserved bit, CRC-beat upper half and tuser carry nothing we use.
    assign unused_s = ^{s_axis_tuser, hdr_r[3], hdr_r[15:14], hdr_r[21:20]};

    // Good DLLP: well-framed CRC beat on the expected VC with a matching CRC.
    always_comb begin
        crc_ok_s    = 1'b0;
        good_dllp_s = 1'b0;
        if (beat_acc_s && (rx_state_r == RX_CRC) && s_axis_tlast &&
            (s_axis_tkeep == KEEP_CRC)) begin
            crc_ok_s = (s_axis_tdata[15:0] == crc_wire_order(crc_calc_r));
        end else begin
            crc_ok_s = 1'b0;
        end
        if (crc_ok_s && (dllp_vc_s == VC_SEL)) begin
            good_dllp_s = 1'b1;
        end else begin
            good_dllp_s = 1'b0;
        end
    end

    // Classify the DLLP type: InitFC1/InitFC2 capture credits, InitFC2/UpdateFC finish FC2.
    always_comb begin
        is_init_s    = 1'b0;
        is_fc2_upd_s = 1'b0;
        case (dllp_type_s)
            4'h4, 4'h5, 4'h6: begin
                is_init_s    = 1'b1;
                is_fc2_upd_s = 1'b0;
            end
            4'hC, 4'hD, 4'hE: begin
                is_init_s    = 1'b1;
                is_fc2_upd_s = 1'b1;
            end
            4'h8, 4'h9, 4'hA: begin
                is_init_s    = 1'b0;
                is_fc2_upd_s = 1'b1;
            end
            default: begin
                is_init_s    = 1'b0;
                is_fc2_upd_s = 1'b0;
            end
        endcase
    end

    // Sink is always ready once out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tready_r <= 1'b0;
        end else begin
            tready_r <= 1'b1;
        end
    end

    // Parse FSM: header beat, CRC beat, and resync after framing errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_r <= RX_HDR;
            hdr_r      <= 32'h0000_0000;
            crc_calc_r <= 16'h0000;
            crc_err_r  <= 1'b0;
        end else begin
            crc_err_r <= 1'b0;
            if (beat_acc_s) begin
                case (rx_state_r)
                    RX_HDR: begin
                        if (s_axis_tlast || (s_axis_tkeep != KEEP_HDR)) begin
                            crc_err_r <= 1'b1;
                        end else begin
                            hdr_r      <= s_axis_tdata[31:0];
                            crc_calc_r <= pcie_datalink_crc(16'hFFFF, s_axis_tdata[31:0]);
                            rx_state_r <= RX_CRC;
                        end
                    end
                    RX_CRC: begin
                        if (s_axis_tlast) begin
                            rx_state_r <= RX_HDR;
                            crc_err_r  <= ~crc_ok_s;
                        end else begin
                            crc_err_r  <= 1'b1;
                            rx_state_r <= RX_DROP;
                        end
                    end
                    RX_DROP: begin
                        if (s_axis_tlast) begin
                            rx_state_r <= RX_HDR;
                        end else begin
                            rx_state_r <= RX_DROP;
                        end
                    end
                    default: begin
                        rx_state_r <= RX_HDR;
                    end
                endcase
            end else begin
                rx_state_r <= rx_state_r;
            end
        end
    end

    // Init FSM: capture first InitFC per type, then wait for any FC2-phase DLLP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_state_r <= ST_IDLE;
            got_p_r      <= 1'b0;
            got_np_r     <= 1'b0;
            got_cpl_r    <= 1'b0;
            fc1_r        <= 1'b0;
            fc2_r        <= 1'b0;
            fc2_pend_r   <= 1'b0;
            ph_r         <= 8'h00;
            nph_r        <= 8'h00;
            cplh_r       <= 8'h00;
            pd_r         <= 12'h000;
            npd_r        <= 12'h000;
            cpld_r       <= 12'h000;
        end else if (!fc_init_en_i) begin
            init_state_r <= ST_IDLE;
            got_p_r      <= 1'b0;
            got_np_r     <= 1'b0;
            got_cpl_r    <= 1'b0;
            fc1_r        <= 1'b0;
            fc2_r        <= 1'b0;
            fc2_pend_r   <= 1'b0;
            ph_r         <= 8'h00;
            nph_r        <= 8'h00;
            cplh_r       <= 8'h00;
            pd_r         <= 12'h000;
            npd_r        <= 12'h000;
            cpld_r       <= 12'h000;
        end else begin
            case (init_state_r)
                ST_IDLE: begin
                    init_state_r <= ST_FC1;
                end
                ST_FC1: begin
                    // Completion is judged on the registered got flags, so the
                    // DLLP that completes FC1 can never also complete FC2.
                    if (got_p_r && got_np_r && got_cpl_r) begin
                        fc1_r        <= 1'b1;
                        init_state_r <= ST_FC2;
                    end else if (good_dllp_s && is_init_s) begin
                        case (fc_class_s)
                            2'd0: begin
                                if (!got_p_r) begin
                                    ph_r    <= hdr_fc_s;
                                    pd_r    <= data_fc_s;
                                    got_p_r <= 1'b1;
                                end else begin
                                    got_p_r <= got_p_r;
                                end
                            end
                            2'd1: begin
                                if (!got_np_r) begin
                                    nph_r    <= hdr_fc_s;
                                    npd_r    <= data_fc_s;
                                    got_np_r <= 1'b1;
                                end else begin
                                    got_np_r <= got_np_r;
                                end
                            end
                            2'd2: begin
                                if (!got_cpl_r) begin
                                    cplh_r    <= hdr_fc_s;
                                    cpld_r    <= data_fc_s;
                                    got_cpl_r <= 1'b1;
                                end else begin
                                    got_cpl_r <= got_cpl_r;
                                end
                            end
                            default: begin
                                got_p_r <= got_p_r;
                            end
                        endcase
                    end else begin
                        init_state_r <= ST_FC1;
                    end
                end
                ST_FC2: begin
                    if (fc2_pend_r) begin
                        fc2_r        <= 1'b1;
                        init_state_r <= ST_DONE;
                    end else if (good_dllp_s && is_fc2_upd_s) begin
                        fc2_pend_r <= 1'b1;
                    end else begin
                        init_state_r <= ST_FC2;
                    end
                end
                ST_DONE: begin
                    init_state_r <= ST_DONE;
                end
                default: begin
                    init_state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign crc_err_o           = crc_err_r;
    assign fc1_values_stored_o = fc1_r;
    assign fc2_values_stored_o = fc2_r;
    assign ph_credits_o        = ph_r;
    assign nph_credits_o       = nph_r;
    assign cplh_credits_o      = cplh_r;
    assign pd_credits_o        = pd_r;
    assign npd_credits_o       = npd_r;
    assign cpld_credits_o      = cpld_r;

endmodule

// File: tb/tb_pcie_flow_ctrl_rx_init.sv
// Directed bench for pcie_flow_ctrl_rx_init: builds DLLPs with a reference
// CRC and checks captured credits, flags and CRC/framing error pulses.
module tb_pcie_flow_ctrl_rx_init;

    logic        clk_i;
    logic        rst_ni;
    logic        fc_init_en_i;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic [2:0]  s_axis_tuser;
    logic        s_axis_tready;
    logic        fc1_values_stored_o;
    logic        fc2_values_stored_o;
    logic [7:0]  ph_credits_o, nph_credits_o, cplh_credits_o;
    logic [11:0] pd_credits_o, npd_credits_o, cpld_credits_o;
    logic        crc_err_o;

    int checks_n   = 0;
    int failures_n = 0;

    pcie_flow_ctrl_rx_init #(
        .DATA_WIDTH(32),
        .USER_WIDTH(3),
        .VC_ID     (0)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .fc_init_en_i        (fc_init_en_i),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tuser        (s_axis_tuser),
        .s_axis_tready       (s_axis_tready),
        .fc1_values_stored_o (fc1_values_stored_o),
        .fc2_values_stored_o (fc2_values_stored_o),
        .ph_credits_o        (ph_credits_o),
        .nph_credits_o       (nph_credits_o),
        .cplh_credits_o      (cplh_credits_o),
        .pd_credits_o        (pd_credits_o),
        .npd_credits_o       (npd_credits_o),
        .cpld_credits_o      (cpld_credits_o),
        .crc_err_o           (crc_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_n++;
        if (obs !== exp) begin
            failures_n++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC, processed byte by byte, LSB of each byte first.
    function automatic logic [15:0] ref_crc(input logic [31:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            b = d[8*k +: 8];
            for (int j = 0; j < 8; j++) begin
                if (c[15] != b[j]) c = (c << 1) ^ 16'h100B;
                else               c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] mirror_bytes(input logic [15:0] c);
        logic [15:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j]     = c[7-j];
            r[8 + j] = c[15-j];
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [3:0] typ, input logic [2:0] vc,
                                           input logic [7:0] h, input logic [11:0] d);
        logic [7:0] b0, b1, b2, b3;
        b0 = {typ, 1'b0, vc};
        b1 = {2'b00, h[7:2]};
        b2 = {h[1:0], 2'b00, d[11:8]};
        b3 = d[7:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        @(negedge clk_i);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic go_idle;
        @(negedge clk_i);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Full DLLP; returns at the falling edge right after the CRC beat is taken.
    task automatic send_dllp(input logic [3:0] typ, input logic [2:0] vc, input logic [7:0] h,
                             input logic [11:0] d, input logic [15:0] crc_flip);
        logic [31:0] hw;
        hw = mk_hdr(typ, vc, h, d);
        send_beat(hw, 4'hF, 1'b0);
        send_beat({16'h0000, mirror_bytes(ref_crc(hw)) ^ crc_flip}, 4'h3, 1'b1);
        go_idle();
    endtask

    initial begin
        rst_ni        = 1'b0;
        fc_init_en_i  = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tkeep  = 4'h0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 3'b101;

        // Reset values
        #12;
        check_val("rst_ctrl", {60'h0, s_axis_tready, fc1_values_stored_o, fc2_values_stored_o, crc_err_o}, 64'h0);
        check_val("rst_credits", {4'h0, ph_credits_o, nph_credits_o, cplh_credits_o,
                  pd_credits_o, npd_credits_o, cpld_credits_o}, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_val("tready_after_rst", {63'h0, s_axis_tready}, 64'h1);

        // FC1 phase
        fc_init_en_i = 1'b1;
        @(negedge clk_i);
        send_dllp(4'h4, 3'd0, 8'h20, 12'h010, 16'h0000);
        check_val("ph_p1", {56'h0, ph_credits_o}, 64'h20);
        check_val("pd_p1", {52'h0, pd_credits_o}, 64'h010);
        check_val("fc1_early", {63'h0, fc1_values_stored_o}, 64'h0);

        // Bad CRC on InitFC1_NP
        send_dllp(4'h5, 3'd0, 8'h11, 12'h022, 16'h0001);
        check_val("crc_err_pulse", {63'h0, crc_err_o}, 64'h1);
        check_val("nph_after_bad_crc", {56'h0, nph_credits_o}, 64'h0);
        @(negedge clk_i);
        check_val("crc_err_one_cycle", {62'h0, crc_err_o, fc1_values_stored_o}, 64'h0);

        // Wrong VC ignored
        send_dllp(4'h4, 3'd1, 8'h33, 12'h333, 16'h0000);
        check_val("ph_vc1_ignored", {56'h0, ph_credits_o}, 64'h20);

        // Framing: header with tlast, then burst without tlast and resync
        send_beat(mk_hdr(4'h5, 3'd0, 8'h11, 12'h022), 4'hF, 1'b1);
        go_idle();
        check_val("hdr_tlast_err", {63'h0, crc_err_o}, 64'h1);
        send_beat(mk_hdr(4'h5, 3'd0, 8'h11, 12'h022), 4'hF, 1'b0);
        send_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
        go_idle();
        check_val("burst_err", {63'h0, crc_err_o}, 64'h1);
        send_beat(32'h1234_5678, 4'hF, 1'b0);
        send_beat(32'h0000_ABCD, 4'h3, 1'b1);
        go_idle();
        check_val("drop_no_err", {63'h0, crc_err_o}, 64'h0);
        send_dllp(4'h5, 3'd0, 8'h11, 12'h022, 16'h0000);
        check_val("nph_resync", {56'h0, nph_credits_o}, 64'h11);
        check_val("npd_resync", {52'h0, npd_credits_o}, 64'h022);

        // InitFC2_Cpl while in FC1 completes FC1 but not FC2
        send_dllp(4'hE, 3'd0, 8'h07, 12'h0AB, 16'h0000);
        check_val("cplh_fc2", {56'h0, cplh_credits_o}, 64'h07);
        check_val("cpld_fc2", {52'h0, cpld_credits_o}, 64'h0AB);
        check_val("fc1_not_yet", {63'h0, fc1_values_stored_o}, 64'h0);
        @(negedge clk_i);
        check_val("fc1_rise", {63'h0, fc1_values_stored_o}, 64'h1);
        @(negedge clk_i);
        check_val("fc2_not_from_same", {63'h0, fc2_values_stored_o}, 64'h0);

        // FC2 phase
        send_dllp(4'hC, 3'd0, 8'h99, 12'h999, 16'h0000);
        check_val("fc2_not_yet", {63'h0, fc2_values_stored_o}, 64'h0);
        check_val("ph_fc2_frozen", {56'h0, ph_credits_o}, 64'h20);
        @(negedge clk_i);
        check_val("fc2_rise", {63'h0, fc2_values_stored_o}, 64'h1);

        // Duplicate InitFC1_P does not overwrite
        send_dllp(4'h4, 3'd0, 8'h05, 12'h005, 16'h0000);
        @(negedge clk_i);
        check_val("ph_dup", {56'h0, ph_credits_o}, 64'h20);
        check_val("flags_held", {62'h0, fc1_values_stored_o, fc2_values_stored_o}, 64'h3);

        // Round two: drop enable while waiting in FC2
        fc_init_en_i = 1'b0;
        @(negedge clk_i);
        check_val("dis_clear_flags", {62'h0, fc1_values_stored_o, fc2_values_stored_o}, 64'h0);
        fc_init_en_i = 1'b1;
        @(negedge clk_i);
        send_dllp(4'h4, 3'd0, 8'h01, 12'h002, 16'h0000);
        send_dllp(4'h5, 3'd0, 8'h03, 12'h004, 16'h0000);
        send_dllp(4'h6, 3'd0, 8'h05, 12'h006, 16'h0000);
        @(negedge clk_i);
        check_val("fc1_round2", {63'h0, fc1_values_stored_o}, 64'h1);
        fc_init_en_i = 1'b0;
        @(negedge clk_i);
        check_val("fc2_drop_flags", {62'h0, fc1_values_stored_o, fc2_values_stored_o}, 64'h0);
        check_val("fc2_drop_credits", {4'h0, ph_credits_o, nph_credits_o, cplh_credits_o,
                  pd_credits_o, npd_credits_o, cpld_credits_o}, 64'h0);

        // Round three: reset asserted in the middle of a CRC beat
        fc_init_en_i = 1'b1;
        @(negedge clk_i);
        send_dllp(4'h4, 3'd0, 8'h44, 12'h055, 16'h0000);
        check_val("ph_round3", {56'h0, ph_credits_o}, 64'h44);
        send_beat(mk_hdr(4'h5, 3'd0, 8'h12, 12'h034), 4'hF, 1'b0);
        send_beat({16'h0000, mirror_bytes(ref_crc(mk_hdr(4'h5, 3'd0, 8'h12, 12'h034)))}, 4'h3, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("midrst_ctrl", {60'h0, s_axis_tready, fc1_values_stored_o, fc2_values_stored_o, crc_err_o}, 64'h0);
        check_val("midrst_credits", {4'h0, ph_credits_o, nph_credits_o, cplh_credits_o,
                  pd_credits_o, npd_credits_o, cpld_credits_o}, 64'h0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule
